// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART frame receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload store: MAX_LEN x 8 registers, one write port, async read port
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - SOF/LEN/payload/CHK frame parser with valid/ready payload drain
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF            = SOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 52080
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_rx_frame_ctrl: parameter out of range");
  end

  state_t          state;
  logic [7:0]      len;
  logic [7:0]      cnt;
  logic [7:0]      chk;
  logic [7:0]      rd_idx;
  logic [7:0]      rd_next;
  logic            buf_we;
  logic [AW-1:0]   buf_waddr;
  logic [AW-1:0]   buf_raddr;
  logic [7:0]      buf_rdata;
  logic            timeout;

  assign busy      = (state != ST_IDLE);
  assign rd_next   = rd_idx + 8'd1;
  assign buf_we    = (state == ST_PAYLOAD) && rx_valid;
  assign buf_waddr = cnt[AW-1:0];
  // While in CHK the read port already points at entry 0, so a good checksum can present it at once.
  assign buf_raddr = (state == ST_DRAIN) ? rd_next[AW-1:0] : '0;

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (rx_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] timer;
  logic          timer_run;

  assign timer_run = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
  // Expires on the edge where the silent-cycle count reaches TIMEOUT_CYCLES-1; a byte on that edge wins.
  assign timeout   = timer_run && !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (!timer_run || rx_valid || timeout) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      len       <= 8'd0;
      cnt       <= 8'd0;
      chk       <= 8'd0;
      rd_idx    <= 8'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
      drop_cnt  <= 8'd0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (timeout) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_valid && rx_data == SOF) begin
              state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (rx_valid) begin
              if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_LEN;
              end else begin
                len   <= rx_data;
                chk   <= rx_data;
                cnt   <= 8'd0;
                state <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (rx_valid) begin
              chk <= chk ^ rx_data;
              cnt <= cnt + 8'd1;
              if (cnt + 8'd1 == len) begin
                state <= ST_CHK;
              end
            end
          end
          ST_CHK: begin
            if (rx_valid) begin
              if (rx_data == chk) begin
                state     <= ST_DRAIN;
                frame_ok  <= 1'b1;
                out_valid <= 1'b1;
                out_data  <= buf_rdata;
                out_last  <= (len == 8'd1);
                rd_idx    <= 8'd0;
              end else begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_CHK;
              end
            end
          end
          ST_DRAIN: begin
            if (rx_valid && drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
            if (out_valid && out_ready) begin
              if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                rd_idx   <= rd_next;
                out_data <= buf_rdata;
                out_last <= (rd_next == len - 8'd1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
